// File: rtl/cla_pkg.sv
// Shared constants, stage-count helper and per-stage control record for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Number of pipeline stages: each stage resolves gps 4-bit groups.
    function automatic int n_stages(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

    // Control bits that travel with each beat: the valid flag and the carry
    // out of the highest group resolved so far.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/cla4_grp.sv
// Combinational 4-bit carry-lookahead group. Produces the sum, the carry out,
// and the group generate/propagate terms for a higher lookahead level.
module cla4_grp
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               co,
    output logic               gg,
    output logic               gp
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is expanded directly from ci, no rippling.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
    assign co = gg | (gp & ci);

    assign s = p ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake and a
// global stall. Stage k resolves groups k*GPS..k*GPS+GPS-1; its carry-out is
// registered and consumed by stage k+1. Result appears after S enabled edges.
// Optional build macro CLA_SAT_EN: clamp the result to signed max/min on
// overflow instead of wrapping.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S  = n_stages(WIDTH, GPS);
    localparam int NG = WIDTH / GROUP_W;
    localparam int SW = GROUP_W * GPS;

`ifdef CLA_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic en;

    stage_ctl_t       ctl_q [S];
    stage_ctl_t       ctl_d [S];
    logic [WIDTH-1:0] a_q   [S];
    logic [WIDTH-1:0] a_d   [S];
    logic [WIDTH-1:0] b_q   [S];
    logic [WIDTH-1:0] b_d   [S];
    logic [WIDTH-1:0] sum_q [S];
    logic [WIDTH-1:0] sum_d [S];
    logic             ovf_q;
    logic             ovf_d;

    // Inputs seen by each stage: live ports for stage 0, the previous
    // stage's registers otherwise.
    logic [WIDTH-1:0] st_a    [S];
    logic [WIDTH-1:0] st_b    [S];
    logic [WIDTH-1:0] sum_src [S];
    logic             st_ci   [S];
    logic             vld_src [S];

    logic [WIDTH-1:0] grp_s;
    logic [NG-1:0]    grp_ci;
    logic [NG-1:0]    grp_co;
    logic [NG-1:0]    grp_gg;
    logic [NG-1:0]    grp_gp;
    logic             msb_ci;

    // Group G/P are available for a block-lookahead level; within a stage the
    // carry simply ripples group to group, so they are not consumed here.
    logic unused_grp_gp;
    assign unused_grp_gp = ^{grp_gg, grp_gp};

    // Whole pipe advances together; a held output freezes every stage.
    assign en       = !ctl_q[S-1].valid || out_ready;
    assign in_ready = en;

    genvar k, g;
    generate
        for (k = 0; k < S; k++) begin : g_src
            if (k == 0) begin : g_first
                // Subtraction as a + ~b + 1: the +1 is the stage-0 carry-in.
                assign st_a[k]    = a;
                assign st_b[k]    = sub ? ~b : b;
                assign st_ci[k]   = sub;
                assign sum_src[k] = '0;
                assign vld_src[k] = in_valid;
            end else begin : g_next
                assign st_a[k]    = a_q[k-1];
                assign st_b[k]    = b_q[k-1];
                assign st_ci[k]   = ctl_q[k-1].carry;
                assign sum_src[k] = sum_q[k-1];
                assign vld_src[k] = ctl_q[k-1].valid;
            end
        end

        for (g = 0; g < NG; g++) begin : g_grp
            localparam int GK = g / GPS;
            if ((g % GPS) == 0) begin : g_cin_stage
                assign grp_ci[g] = st_ci[GK];
            end else begin : g_cin_ripple
                assign grp_ci[g] = grp_co[g-1];
            end

            cla4_grp u_grp (
                .a  (st_a[GK][g*GROUP_W +: GROUP_W]),
                .b  (st_b[GK][g*GROUP_W +: GROUP_W]),
                .ci (grp_ci[g]),
                .s  (grp_s[g*GROUP_W +: GROUP_W]),
                .co (grp_co[g]),
                .gg (grp_gg[g]),
                .gp (grp_gp[g])
            );
        end
    endgenerate

    // Next-state for every stage: merge this stage's sum slice into the
    // forwarded lower slices; derive overflow and optional clamp at the end.
    always_comb begin
        for (int i = 0; i < S; i++) begin
            ctl_d[i].valid = vld_src[i];
            ctl_d[i].carry = grp_co[i*GPS + GPS - 1];
            a_d[i]         = st_a[i];
            b_d[i]         = st_b[i];
            sum_d[i]       = sum_src[i];
            sum_d[i][i*SW +: SW] = grp_s[i*SW +: SW];
        end
        // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
        msb_ci = grp_s[WIDTH-1] ^ st_a[S-1][WIDTH-1] ^ st_b[S-1][WIDTH-1];
        ovf_d  = msb_ci ^ grp_co[NG-1];
`ifdef CLA_SAT_EN
        if (ovf_d) begin
            sum_d[S-1] = st_a[S-1][WIDTH-1] ? SMIN : SMAX;
        end
`endif
    end

    // Pipeline registers: synchronous clear, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                ctl_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < S; i++) begin
                ctl_q[i] <= ctl_d[i];
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                sum_q[i] <= sum_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = ctl_q[S-1].valid;
    assign sum       = sum_q[S-1];
    assign cout      = ctl_q[S-1].carry;
    assign ovf       = ovf_q;

endmodule
